// File: rtl/test_scheduler_pkg.sv
// Shared types for the test scheduler: FSM states, report severities
// and the launch-id width helper.
package test_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_NEXT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SEV_INFO    = 2'd0,
      SEV_WARNING = 2'd1,
      SEV_ERROR   = 2'd2,
      SEV_FATAL   = 2'd3
   } sev_t;

   // The id width never drops below one bit, even for a single test.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/test_scheduler_sat_counter.sv
// Saturating up-counter with two independent increment strobes, so that
// two events landing in the same cycle both count.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         inc2,
   output logic [W-1:0] count
);

   localparam int unsigned SW = W + 2;
   localparam logic [SW-1:0] MAXV = (SW'(1) << W) - SW'(1);

   logic [SW-1:0] sum;

   always_comb sum = SW'(count) + SW'(inc) + SW'(inc2);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (sum > MAXV) begin
         count <= '1;
      end else begin
         count <= sum[W-1:0];
      end
   end

endmodule

// File: rtl/test_scheduler.sv
// Runs a fixed list of tests over a valid/ready launch handshake, with a
// per-test watchdog, severity statistics and one end-of-run verdict pulse.
module test_scheduler
   import test_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_TESTS = 4,
   parameter  int unsigned TIMEOUT   = 1024,
   parameter  int unsigned CNT_W     = 8,
   localparam int unsigned ID_W      = id_width(NUM_TESTS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic             o_test_valid,
   input  logic             i_test_ready,
   output logic [ID_W-1:0]  o_test_id,
   input  logic             i_test_done,
   input  logic             i_test_pass,
   input  logic             i_rpt_valid,
   input  logic [1:0]       i_rpt_sev,
   output logic             o_test_kill,
   output logic             o_busy,
   output logic             o_finish,
   output logic             o_pass,
   output logic [CNT_W-1:0] o_info_cnt,
   output logic [CNT_W-1:0] o_warn_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_timeout_cnt
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_TESTS - 1);

   state_t          state, state_nxt;
   logic [ID_W-1:0] id, id_nxt;
   logic [WD_W-1:0] wd, wd_nxt;
   logic            fatal, fatal_nxt;
   logic            kill_nxt;
   logic            clr;
   logic            counting;
   logic            rpt_fatal;
   logic            info_inc, warn_inc, err_rpt, err_done, tmo_inc;
   logic            pass_nxt;
   sev_t            sev;

   assign sev      = sev_t'(i_rpt_sev);
   assign counting = (state == S_LAUNCH) || (state == S_RUN) || (state == S_NEXT);

   // Next-state, watchdog and statistics strobes
   always_comb begin
      state_nxt = state;
      id_nxt    = id;
      wd_nxt    = wd;
      fatal_nxt = fatal;
      kill_nxt  = 1'b0;
      clr       = 1'b0;
      info_inc  = 1'b0;
      warn_inc  = 1'b0;
      err_rpt   = 1'b0;
      err_done  = 1'b0;
      tmo_inc   = 1'b0;
      rpt_fatal = 1'b0;

      if (counting && i_rpt_valid) begin
         case (sev)
            SEV_INFO:    info_inc = 1'b1;
            SEV_WARNING: warn_inc = 1'b1;
            SEV_ERROR:   err_rpt  = 1'b1;
            SEV_FATAL: begin
               err_rpt   = 1'b1;
               rpt_fatal = 1'b1;
            end
            default: ;
         endcase
      end

      case (state)
         S_IDLE: begin
            if (i_start) begin
               clr       = 1'b1;
               fatal_nxt = 1'b0;
               id_nxt    = '0;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (i_test_ready) begin
               wd_nxt    = '0;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            wd_nxt = wd + WD_W'(1);
            if (i_test_done) begin
               err_done  = !i_test_pass;
               state_nxt = S_NEXT;
            end else if (wd == WD_LAST) begin
               kill_nxt  = 1'b1;
               tmo_inc   = 1'b1;
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (fatal || (id == ID_LAST)) begin
               state_nxt = S_DONE;
            end else begin
               id_nxt    = id + ID_W'(1);
               state_nxt = S_LAUNCH;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // A fatal report pre-empts everything: kill now, park in NEXT for the
      // kill cycle, then finish without launching anything else.
      if (rpt_fatal) begin
         fatal_nxt = 1'b1;
         kill_nxt  = 1'b1;
         err_done  = 1'b0;
         tmo_inc   = 1'b0;
         id_nxt    = id;
         wd_nxt    = wd;
         state_nxt = fatal ? S_DONE : S_NEXT;
      end
   end

   // Verdict includes any error or timeout counted in the same cycle
   assign pass_nxt = (o_err_cnt == '0) && !err_done && !err_rpt &&
                     (o_timeout_cnt == '0) && !tmo_inc && !fatal_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         id           <= '0;
         wd           <= '0;
         fatal        <= 1'b0;
         o_test_valid <= 1'b0;
         o_test_kill  <= 1'b0;
         o_busy       <= 1'b0;
         o_finish     <= 1'b0;
         o_pass       <= 1'b0;
      end else begin
         state        <= state_nxt;
         id           <= id_nxt;
         wd           <= wd_nxt;
         fatal        <= fatal_nxt;
         o_test_valid <= (state_nxt == S_LAUNCH);
         o_test_kill  <= kill_nxt;
         o_busy       <= (state_nxt != S_IDLE);
         o_finish     <= (state_nxt == S_DONE);
         if (clr) begin
            o_pass <= 1'b0;
         end else if (state_nxt == S_DONE) begin
            o_pass <= pass_nxt;
         end
      end
   end

   assign o_test_id = id;

   sat_counter #(.W(CNT_W)) u_info_cnt (
      .clk(i_clk), .rst(i_rst), .clr(clr), .inc(info_inc), .inc2(1'b0), .count(o_info_cnt)
   );
   sat_counter #(.W(CNT_W)) u_warn_cnt (
      .clk(i_clk), .rst(i_rst), .clr(clr), .inc(warn_inc), .inc2(1'b0), .count(o_warn_cnt)
   );
   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk(i_clk), .rst(i_rst), .clr(clr), .inc(err_done), .inc2(err_rpt), .count(o_err_cnt)
   );
   sat_counter #(.W(CNT_W)) u_timeout_cnt (
      .clk(i_clk), .rst(i_rst), .clr(clr), .inc(tmo_inc), .inc2(1'b0), .count(o_timeout_cnt)
   );

endmodule

// File: tb/tb_test_scheduler.sv
// Bench for test_scheduler: directed scenario table, random scenarios scored
// by a per-test behavioural model, and hand sequences for reset/ignore rules.
module tb_test_scheduler;

   localparam int unsigned NT    = 4;
   localparam int unsigned TO    = 8;
   localparam int unsigned CW    = 2;
   localparam int unsigned NSLOT = 3;
   localparam int unsigned NDIR  = 10;
   localparam int unsigned NRAND = 40;

   logic          clk = 1'b0;
   logic          rst, start, ready, done, pass, rpt_valid;
   logic [1:0]    rpt_sev;
   logic          valid, kill, busy, finish, agg_pass;
   logic [1:0]    id;
   logic [CW-1:0] info_cnt, warn_cnt, err_cnt, tmo_cnt;

   int checks = 0;
   int errors = 0;
   int kill_seen = 0;

   // One scenario: per-test behaviour plus the expected end-of-run results.
   // len = RUN cycle carrying done (0 or > TO: never); rcyc = RUN cycle of a report (0: none).
   typedef struct packed {
      logic [NT-1:0][3:0]            len;
      logic [NT-1:0]                 ok;
      logic [NT-1:0][1:0]            rdy;
      logic [NT-1:0][NSLOT-1:0][3:0] rcyc;
      logic [NT-1:0][NSLOT-1:0][1:0] rsev;
      logic [CW-1:0]                 e_info, e_warn, e_err, e_tmo;
      logic [2:0]                    e_kill, e_ntests;
      logic                          e_pass;
   } vec_t;

   vec_t tbl [NDIR];

   test_scheduler #(.NUM_TESTS(NT), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_test_valid(valid), .i_test_ready(ready), .o_test_id(id),
      .i_test_done(done), .i_test_pass(pass),
      .i_rpt_valid(rpt_valid), .i_rpt_sev(rpt_sev),
      .o_test_kill(kill), .o_busy(busy), .o_finish(finish), .o_pass(agg_pass),
      .o_info_cnt(info_cnt), .o_warn_cnt(warn_cnt), .o_err_cnt(err_cnt),
      .o_timeout_cnt(tmo_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (kill) kill_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] sat(input int n);
      int mx;
      mx = (1 << CW) - 1;
      return (n > mx) ? CW'(mx) : CW'(n);
   endfunction

   // {valid, sev} of the report issued on RUN cycle c of test t (first slot wins)
   function automatic logic [2:0] rpt_at(input vec_t v, input int t, input int c);
      for (int s = 0; s < NSLOT; s++)
         if (int'(v.rcyc[t][s]) == c) return {1'b1, v.rsev[t][s]};
      return 3'b000;
   endfunction

   function automatic bit finishes(input vec_t v, input int t);
      return (v.len[t] != 4'd0) && (int'(v.len[t]) <= TO);
   endfunction

   // Reference: walk tests in order, tally reports, verdicts and timeouts;
   // a fatal report ends the whole run.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int n_info, n_warn, n_err, n_tmo, n_kill, n_tests, last;
      bit fatal;
      logic [2:0] rp;
      r = v;
      n_info = 0; n_warn = 0; n_err = 0; n_tmo = 0; n_kill = 0; n_tests = 0;
      fatal = 1'b0;
      for (int t = 0; t < NT && !fatal; t++) begin
         n_tests++;
         last = finishes(v, t) ? int'(v.len[t]) : TO;
         for (int c = 1; c <= last && !fatal; c++) begin
            rp = rpt_at(v, t, c);
            if (rp[2]) begin
               case (rp[1:0])
                  2'd0: n_info++;
                  2'd1: n_warn++;
                  2'd2: n_err++;
                  default: begin n_err++; n_kill++; fatal = 1'b1; end
               endcase
            end
         end
         if (!fatal) begin
            if (!finishes(v, t)) begin n_tmo++; n_kill++; end
            else if (!v.ok[t]) n_err++;
         end
      end
      r.e_info   = sat(n_info);
      r.e_warn   = sat(n_warn);
      r.e_err    = sat(n_err);
      r.e_tmo    = sat(n_tmo);
      r.e_kill   = 3'(n_kill);
      r.e_ntests = 3'(n_tests);
      r.e_pass   = (n_err == 0) && (n_tmo == 0) && !fatal;
      return r;
   endfunction

   function automatic vec_t base();
      vec_t v;
      v = '0;
      for (int t = 0; t < NT; t++) begin
         v.len[t] = 4'd5;
         v.ok[t]  = 1'b1;
      end
      return v;
   endfunction

   function automatic vec_t expect_set(input vec_t v, input int i, input int w, input int e,
                                       input int tm, input int k, input int nt, input bit p);
      vec_t r;
      r = v;
      r.e_info = CW'(i); r.e_warn = CW'(w); r.e_err = CW'(e); r.e_tmo = CW'(tm);
      r.e_kill = 3'(k); r.e_ntests = 3'(nt); r.e_pass = p;
      return r;
   endfunction

   task automatic do_reset(input int idx);
      rst = 1'b1; start = 1'b0; ready = 1'b0; done = 1'b0; pass = 1'b0;
      rpt_valid = 1'b0; rpt_sev = 2'd0;
      tick();
      rst = 1'b0;
      chk("rst_valid", idx, int'(valid), 0);
      chk("rst_busy", idx, int'(busy), 0);
      chk("rst_kill", idx, int'(kill), 0);
      chk("rst_finish", idx, int'(finish), 0);
      chk("rst_pass", idx, int'(agg_pass), 0);
      chk("rst_id", idx, int'(id), 0);
      chk("rst_cnts", idx, int'({info_cnt, warn_cnt, err_cnt, tmo_cnt}), 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int kills0, nlaunch, last;
      bit stop, fat;
      logic [2:0] rp;
      do_reset(idx);
      kills0 = kill_seen; nlaunch = 0; stop = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("busy_after_start", idx, int'(busy), 1);
      for (int t = 0; t < NT && !stop; t++) begin
         chk("launch_valid", idx, int'(valid), 1);
         chk("launch_id", idx, int'(id), t);
         nlaunch++;
         for (int r = 0; r < int'(v.rdy[t]); r++) tick();
         ready = 1'b1; tick(); ready = 1'b0;
         chk("valid_drop", idx, int'(valid), 0);
         last = finishes(v, t) ? int'(v.len[t]) : TO;
         fat  = 1'b0;
         for (int c = 1; c <= last; c++) begin
            rp = rpt_at(v, t, c);
            done = (c == int'(v.len[t])); pass = v.ok[t];
            rpt_valid = rp[2]; rpt_sev = rp[1:0];
            fat = rp[2] && (rp[1:0] == 2'd3);
            tick();
            done = 1'b0; pass = 1'b0; rpt_valid = 1'b0;
            if (fat) break;
         end
         // one cycle after the deciding RUN cycle: kill only on timeout or fatal
         chk("kill_pulse", idx, int'(kill), int'(fat || !finishes(v, t)));
         tick();
         if (fat || t == NT - 1) begin
            chk("finish_pulse", idx, int'(finish), 1);
            stop = 1'b1;
         end
      end
      chk("busy_in_done", idx, int'(busy), 1);
      chk("info_cnt", idx, int'(info_cnt), int'(v.e_info));
      chk("warn_cnt", idx, int'(warn_cnt), int'(v.e_warn));
      chk("err_cnt", idx, int'(err_cnt), int'(v.e_err));
      chk("timeout_cnt", idx, int'(tmo_cnt), int'(v.e_tmo));
      chk("verdict", idx, int'(agg_pass), int'(v.e_pass));
      chk("tests_launched", idx, nlaunch, int'(v.e_ntests));
      chk("kill_total", idx, kill_seen - kills0, int'(v.e_kill));
      tick();
      chk("finish_single", idx, int'(finish), 0);
      chk("busy_idle", idx, int'(busy), 0);
      chk("verdict_held", idx, int'(agg_pass), int'(v.e_pass));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1);
   end

   initial begin
      vec_t v;
      tbl[0] = expect_set(base(), 0, 0, 0, 0, 0, 4, 1'b1);
      v = base();
      v.rcyc[1][0] = 4'd1; v.rsev[1][0] = 2'd1;
      v.rcyc[1][1] = 4'd2; v.rsev[1][1] = 2'd2;
      v.rcyc[1][2] = 4'd3; v.rsev[1][2] = 2'd0;
      tbl[1] = expect_set(v, 1, 1, 1, 0, 0, 4, 1'b0);
      v = base(); v.len[2] = 4'd0;
      tbl[2] = expect_set(v, 0, 0, 0, 1, 1, 4, 1'b0);
      v = base(); v.rcyc[1][0] = 4'd2; v.rsev[1][0] = 2'd3;
      tbl[3] = expect_set(v, 0, 0, 1, 0, 1, 2, 1'b0);
      v = base(); v.len[0] = 4'(TO);
      tbl[4] = expect_set(v, 0, 0, 0, 0, 0, 4, 1'b1);
      v = base(); v.len[1] = 4'd3; v.ok[1] = 1'b0; v.rcyc[1][0] = 4'd3; v.rsev[1][0] = 2'd3;
      tbl[5] = expect_set(v, 0, 0, 1, 0, 1, 2, 1'b0);
      v = base();
      v.rcyc[0][0] = 4'd1; v.rcyc[0][1] = 4'd2; v.rcyc[0][2] = 4'd3;
      v.rcyc[1][0] = 4'd1; v.rcyc[1][1] = 4'd2;
      tbl[6] = expect_set(v, 3, 0, 0, 0, 0, 4, 1'b1);
      v = base(); v.len[0] = 4'd4; v.ok[0] = 1'b0; v.rcyc[0][0] = 4'd4; v.rsev[0][0] = 2'd2;
      v.ok[2] = 1'b0;
      tbl[7] = expect_set(v, 0, 0, 3, 0, 0, 4, 1'b0);
      v = base(); v.len[3] = 4'd9; v.rdy[3] = 2'd2;
      tbl[8] = expect_set(v, 0, 0, 0, 1, 1, 4, 1'b0);
      v = base(); v.rcyc[3][0] = 4'd1; v.rsev[3][0] = 2'd3;
      tbl[9] = expect_set(v, 0, 0, 1, 0, 1, 4, 1'b0);

      for (int i = 0; i < NDIR; i++) run_vec(tbl[i], i);

      // Mid-RUN reset, with i_start ignored while busy
      do_reset(100);
      start = 1'b1; tick(); start = 1'b0;
      ready = 1'b1; tick(); ready = 1'b0;
      rpt_valid = 1'b1; rpt_sev = 2'd0; tick();
      start = 1'b1; tick(); start = 1'b0; rpt_valid = 1'b0;
      chk("start_ignored_busy", 100, int'(info_cnt), 2);
      chk("no_relaunch", 100, int'(valid), 0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrun_rst_busy", 100, int'(busy), 0);
      chk("midrun_rst_info", 100, int'(info_cnt), 0);
      chk("midrun_rst_valid", 100, int'(valid), 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_valid", 100, int'(valid), 1);
      chk("restart_id", 100, int'(id), 0);

      // Reports in LAUNCH/NEXT count, in DONE/IDLE do not; done outside RUN ignored
      do_reset(101);
      start = 1'b1; tick(); start = 1'b0;
      rpt_valid = 1'b1; rpt_sev = 2'd1; done = 1'b1; pass = 1'b0; tick();
      rpt_valid = 1'b0; done = 1'b0;
      chk("launch_rpt_warn", 101, int'(warn_cnt), 1);
      chk("launch_done_ignored", 101, int'(err_cnt), 0);
      chk("still_launching", 101, int'(valid), 1);
      ready = 1'b1; tick(); ready = 1'b0;
      done = 1'b1; pass = 1'b1; tick(); done = 1'b0;
      rpt_valid = 1'b1; rpt_sev = 2'd0; tick(); rpt_valid = 1'b0;
      chk("next_rpt_info", 101, int'(info_cnt), 1);
      chk("next_launch_id", 101, int'(id), 1);
      for (int t = 1; t < NT; t++) begin
         ready = 1'b1; tick(); ready = 1'b0;
         done = 1'b1; pass = 1'b1; tick(); done = 1'b0;
         tick();
      end
      chk("seq_finish", 101, int'(finish), 1);
      rpt_valid = 1'b1; rpt_sev = 2'd2; tick(); rpt_valid = 1'b0;
      chk("done_rpt_ignored", 101, int'(err_cnt), 0);
      chk("seq_verdict", 101, int'(agg_pass), 1);
      rpt_valid = 1'b1; rpt_sev = 2'd1; tick(); rpt_valid = 1'b0;
      chk("idle_rpt_ignored", 101, int'(warn_cnt), 1);

      // Random scenarios scored by the model
      for (int i = 0; i < NRAND; i++) begin
         v = '0;
         for (int t = 0; t < NT; t++) begin
            v.len[t] = 4'($urandom_range(0, 10));
            v.ok[t]  = ($urandom_range(0, 3) != 0);
            v.rdy[t] = 2'($urandom_range(0, 2));
            for (int s = 0; s < NSLOT; s++) begin
               v.rcyc[t][s] = 4'($urandom_range(0, 9));
               v.rsev[t][s] = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
         end
         run_vec(model(v), 200 + i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
